// File: rtl/synth_tone_gen_if.sv
// Audio codec sample channel: ready/write handshake plus 24-bit stereo sample.
interface synth_tone_gen_if;
    logic        audio_ready;
    logic        audio_write;
    logic [23:0] audio_left;
    logic [23:0] audio_right;

    // Tone generator side: produces samples and the write strobe.
    modport master (
        input  audio_ready,
        output audio_write,
        output audio_left,
        output audio_right
    );

    // Codec side: signals FIFO space and consumes samples.
    modport slave (
        output audio_ready,
        input  audio_write,
        input  audio_left,
        input  audio_right
    );
endinterface

// File: rtl/synth_tone_gen.sv
// Square-wave tone generator driven by a one-hot key vector, with a linear
// release envelope and a ready/write sample handshake toward the audio codec.
module synth_tone_gen #(
    parameter int unsigned       DIV_A       = 95556,
    parameter int unsigned       DIV_S       = 85131,
    parameter int unsigned       DIV_D       = 75843,
    parameter int unsigned       DIV_F       = 71586,
    parameter logic signed [23:0] AMPLITUDE  = 24'sd8000000,
    parameter int unsigned       DECAY_TICKS = 5000,
    parameter logic [23:0]       DECAY_STEP  = 24'd16000,
    parameter int unsigned       SAMPLE_DIV  = 1042
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [3:0]             keyboard_data,
    synth_tone_gen_if.master       audio,
    output logic                   note_active,
    output logic                   overrun
);

    localparam int unsigned SdW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned DcW = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
    localparam logic [23:0] AmpMag = AMPLITUDE;

    typedef enum logic [1:0] {StIdle, StPlay, StRelease} state_e;

    state_e           state_q, state_d;
    logic [3:0]       ks_meta_q, ks_q, ks_prev_q;
    logic [16:0]      div_q, div_d;
    logic [16:0]      cnt_q, cnt_d;
    logic             level_q, level_d;
    logic [23:0]      amp_q, amp_d;
    logic [DcW-1:0]   dcnt_q, dcnt_d;
    logic [SdW-1:0]   sdiv_q;
    logic             pending_q;
    logic [23:0]      left_q;
    logic             overrun_q;
    logic             note_active_q;

    logic [16:0]      sel_div;
    logic [23:0]      wave;
    logic             tick;
    logic             write;

    // Two-flop synchroniser for the asynchronous key vector, plus last-cycle copy.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ks_meta_q <= '0;
            ks_q      <= '0;
            ks_prev_q <= '0;
        end else begin
            ks_meta_q <= keyboard_data;
            ks_q      <= ks_meta_q;
            ks_prev_q <= ks_q;
        end
    end

    // Highest set key wins: A > S > D > F.
    always_comb begin
        sel_div = 17'(DIV_F);
        if (ks_q[3]) begin
            sel_div = 17'(DIV_A);
        end else if (ks_q[2]) begin
            sel_div = 17'(DIV_S);
        end else if (ks_q[1]) begin
            sel_div = 17'(DIV_D);
        end
    end

    // Note FSM state and oscillator/envelope registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= StIdle;
            div_q         <= '0;
            cnt_q         <= '0;
            level_q       <= 1'b0;
            amp_q         <= '0;
            dcnt_q        <= '0;
            note_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            cnt_q         <= cnt_d;
            level_q       <= level_d;
            amp_q         <= amp_d;
            dcnt_q        <= dcnt_d;
            note_active_q <= (state_d != StIdle);
        end
    end

    // Next-state: oscillator runs by default while sounding; key events override it.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        amp_d   = amp_q;
        dcnt_d  = dcnt_q;

        if (state_q != StIdle) begin
            if (cnt_q == div_q - 17'd1) begin
                cnt_d   = '0;
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 17'd1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (ks_q != 4'd0) begin
                    state_d = StPlay;
                    div_d   = sel_div;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    amp_d   = AmpMag;
                end
            end
            StPlay: begin
                if (ks_q == 4'd0) begin
                    state_d = StRelease;
                    dcnt_d  = '0;
                end else if (ks_q != ks_prev_q) begin
                    // Note change keeps phase level and amplitude, restarts the half-period.
                    div_d   = sel_div;
                    cnt_d   = '0;
                    level_d = level_q;
                end
            end
            StRelease: begin
                if (ks_q != 4'd0) begin
                    state_d = StPlay;
                    amp_d   = AmpMag;
                    div_d   = sel_div;
                    cnt_d   = '0;
                    level_d = level_q;
                end else if (dcnt_q == DcW'(DECAY_TICKS - 1)) begin
                    dcnt_d = '0;
                    if (amp_q > DECAY_STEP) begin
                        amp_d = amp_q - DECAY_STEP;
                    end else begin
                        amp_d   = '0;
                        state_d = StIdle;
                    end
                end else begin
                    dcnt_d = dcnt_q + DcW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Instantaneous wave value: silent when idle, otherwise +/- amplitude.
    always_comb begin
        wave = '0;
        if (state_q != StIdle) begin
            wave = level_q ? amp_q : (24'd0 - amp_q);
        end
    end

    assign tick  = (sdiv_q == SdW'(SAMPLE_DIV - 1));
    assign write = pending_q & audio.audio_ready;

    // Sample divider, sample latch, pending flag and sticky overrun.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sdiv_q    <= '0;
            pending_q <= 1'b0;
            left_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            sdiv_q <= tick ? '0 : sdiv_q + SdW'(1);
            if (tick) begin
                left_q    <= wave;
                pending_q <= 1'b1;
                // A write in the same cycle drains the old sample, so no overrun.
                if (pending_q && !write) begin
                    overrun_q <= 1'b1;
                end
            end else if (write) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign audio.audio_write = write;
    assign audio.audio_left  = left_q;
    assign audio.audio_right = left_q;
    assign note_active       = note_active_q;
    assign overrun           = overrun_q;

endmodule

// File: tb/tb_synth_tone_gen.sv
// Randomised bench for synth_tone_gen: a timeline-based reference model pushes
// expected samples into a scoreboard queue, a negedge monitor pops and compares.
module tb_synth_tone_gen;

    localparam int DivA = 4;
    localparam int DivS = 5;
    localparam int DivD = 6;
    localparam int DivF = 7;
    localparam int SampleDiv = 3;
    localparam int DecayTicks = 2;
    localparam int Amp = 100;
    localparam int Step = 30;

    logic       clock = 1'b0;
    logic       resetn;
    logic [3:0] keyboard_data;
    logic       note_active;
    logic       overrun;

    synth_tone_gen_if aif ();

    synth_tone_gen #(
        .DIV_A       (DivA),
        .DIV_S       (DivS),
        .DIV_D       (DivD),
        .DIV_F       (DivF),
        .AMPLITUDE   (24'sd100),
        .DECAY_TICKS (DecayTicks),
        .DECAY_STEP  (24'd30),
        .SAMPLE_DIV  (SampleDiv)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .keyboard_data (keyboard_data),
        .audio         (aif.master),
        .note_active   (note_active),
        .overrun       (overrun)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit mid_rst_armed = 1'b0;
    bit rst_seen = 1'b0;

    // Reference model: note described by time since (re)load and time since release.
    typedef enum {MOff, MOn, MFade} mmode_t;
    mmode_t     m_mode;
    int         m_n, m_half, m_t, m_lvl0, m_amp, m_r;
    logic [3:0] m_h0, m_h1, m_prev;
    bit         m_pend, m_ovr;
    int         exp_q[$];

    function automatic int pick_div(input logic [3:0] k);
        if (k[3]) return DivA;
        if (k[2]) return DivS;
        if (k[1]) return DivD;
        return DivF;
    endfunction

    function automatic int level_now();
        return m_lvl0 ^ ((m_t / m_half) % 2);
    endfunction

    function automatic int wave_now();
        if (m_mode == MOff) return 0;
        return (level_now() != 0) ? m_amp : -m_amp;
    endfunction

    initial begin
        forever begin
            @(posedge clock);
            if (!resetn) begin
                m_mode = MOff; m_n = 0; m_half = 1; m_t = 0; m_lvl0 = 0; m_amp = 0; m_r = 0;
                m_h0 = '0; m_h1 = '0; m_prev = '0; m_pend = 1'b0; m_ovr = 1'b0;
                exp_q.delete();
            end else begin
                int         w;
                bit         wr;
                logic [3:0] ks;
                w  = wave_now();
                wr = m_pend && aif.audio_ready;
                ks = m_h1;
                m_n++;
                if (m_n % SampleDiv == 0) begin
                    if (m_pend && !wr) begin
                        m_ovr = 1'b1;
                        exp_q[exp_q.size() - 1] = w;
                    end else begin
                        exp_q.push_back(w);
                    end
                    m_pend = 1'b1;
                end else if (wr) begin
                    m_pend = 1'b0;
                end
                case (m_mode)
                    MOff: if (ks != 0) begin
                        m_mode = MOn; m_half = pick_div(ks); m_t = 0; m_lvl0 = 1; m_amp = Amp;
                    end
                    MOn: if (ks == 0) begin
                        m_mode = MFade; m_r = 0; m_t++;
                    end else if (ks != m_prev) begin
                        m_lvl0 = level_now(); m_half = pick_div(ks); m_t = 0;
                    end else begin
                        m_t++;
                    end
                    MFade: if (ks != 0) begin
                        m_lvl0 = level_now(); m_mode = MOn; m_amp = Amp;
                        m_half = pick_div(ks); m_t = 0;
                    end else begin
                        m_t++; m_r++;
                        m_amp = Amp - Step * (m_r / DecayTicks);
                        if (m_amp <= 0) begin
                            m_amp = 0; m_mode = MOff;
                        end
                    end
                    default: m_mode = MOff;
                endcase
                m_prev = ks;
                m_h1 = m_h0;
                m_h0 = keyboard_data;
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle flag checks, scoreboard pop on each write, async reset probe.
    initial begin
        forever begin
            @(negedge clock or negedge resetn);
            if (!resetn) begin
                if (mid_rst_armed && !rst_seen) begin
                    rst_seen = 1'b1;
                    #1;
                    check("rst_write", longint'(aif.audio_write), 0);
                    check("rst_left", longint'(aif.audio_left), 0);
                    check("rst_right", longint'(aif.audio_right), 0);
                    check("rst_note_active", longint'(note_active), 0);
                    check("rst_overrun", longint'(overrun), 0);
                end
            end else if (clock == 1'b0) begin
                check("note_active", longint'(note_active), longint'(m_mode != MOff));
                check("overrun", longint'(overrun), longint'(m_ovr));
                check("write_strobe", longint'(aif.audio_write),
                      longint'(m_pend && aif.audio_ready));
                if (aif.audio_write) begin
                    check("write_needs_ready", longint'(aif.audio_ready), 1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 1, 0);
                    end else begin
                        int e;
                        e = exp_q.pop_front();
                        check("sample_left", longint'($signed(aif.audio_left)), longint'(e));
                        check("sample_right", longint'($signed(aif.audio_right)), longint'(e));
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    initial begin
        resetn = 1'b0;
        keyboard_data = 4'b0000;
        aif.audio_ready = 1'b0;
        cyc(3);
        resetn = 1'b1;
        keyboard_data = 4'b1000;
        aif.audio_ready = 1'b1;
        cyc(30);
        keyboard_data = 4'b0001;
        cyc(40);
        keyboard_data = 4'b0000;
        cyc(30);
        keyboard_data = 4'b1000;
        cyc(12);
        keyboard_data = 4'b0000;
        cyc(5);
        // Lands the retrigger while the release amplitude sits at 40.
        keyboard_data = 4'b0100;
        cyc(30);
        aif.audio_ready = 1'b0;
        cyc(8);
        aif.audio_ready = 1'b1;
        cyc(10);
        keyboard_data = 4'b0000;
        cyc(30);
        for (int i = 0; i < 400; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 3) keyboard_data = 4'b0000;
            else if (sel < 8) keyboard_data = 4'(1 << $urandom_range(0, 3));
            else keyboard_data = 4'($urandom_range(1, 15));
            aif.audio_ready = ($urandom_range(0, 3) != 0);
            cyc(int'($urandom_range(1, 12)));
        end
        keyboard_data = 4'b1000;
        aif.audio_ready = 1'b0;
        cyc(20);
        aif.audio_ready = 1'b1;
        cyc(1);
        mid_rst_armed = 1'b1;
        resetn = 1'b0;
        cyc(3);
        resetn = 1'b1;
        keyboard_data = 4'b0010;
        cyc(20);
        keyboard_data = 4'b0000;
        cyc(20);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
